// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 2-entry instruction buffer.
//
// Issues one instruction-memory read at a time from req_addr. The branch
// predictor sees the same address on bp_pc and supplies the next PC
// combinationally. Returned words are buffered with their PC, predicted
// next PC and BTB hit flag. Decode drains the buffer through if_*/id_ready.
// A redirect from ID/EX flushes the buffer and restarts fetch at
// redirect_pc. If a read is still outstanding at that point, the read is
// allowed to complete and its data is discarded.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_readM, i_address         instruction-memory read request / address
//   i_data, i_ready            returned instruction word / read completes
//   bp_pc                      PC currently being fetched (to predictor)
//   bp_predicted_pc            predictor's next PC for bp_pc
//   bp_tag_match               predictor BTB hit for bp_pc
//   redirect_valid/_pc         fetch redirect from ID/EX
//   if_valid, if_instr, if_pc  buffer head to decode
//   if_pred_pc, if_tag_match   prediction captured with the head entry
//   id_ready                   decode accepts the head this cycle
module fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] bp_pc,
  input  logic [WORD_SIZE-1:0] bp_predicted_pc,
  input  logic                 bp_tag_match,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 if_valid,
  output logic [WORD_SIZE-1:0] if_instr,
  output logic [WORD_SIZE-1:0] if_pc,
  output logic [WORD_SIZE-1:0] if_pred_pc,
  output logic                 if_tag_match,
  input  logic                 id_ready
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,  // read outstanding, result will be buffered
    WAIT_SPACE = 2'd1,  // buffer full, no read outstanding
    DISCARD    = 2'd2   // read outstanding, result will be dropped
  } state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pred_pc;
    logic                 tag_match;
  } entry_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
  logic [WORD_SIZE-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]           count_q, count_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 wr_ptr_q, wr_ptr_d;
  entry_t               fifo_q [2];
  entry_t               fifo_d [2];

  logic                 push;
  logic                 pop;
  logic [1:0]           count_after_push;
  entry_t               head;

  assign head = fifo_q[rd_ptr_q];

  // Read request and head-valid are forced low while reset is asserted so
  // nothing leaks out during the reset cycle(s).
  assign i_readM      = !reset && (state_q != WAIT_SPACE);
  assign i_address    = req_addr_q;
  assign bp_pc        = req_addr_q;
  assign if_valid     = !reset && (count_q != '0);
  assign if_instr     = head.instr;
  assign if_pc        = head.pc;
  assign if_pred_pc   = head.pred_pc;
  assign if_tag_match = head.tag_match;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pend_pc_d  = pend_pc_q;
    push       = 1'b0;
    pop        = (count_q != '0) && id_ready && !redirect_valid;
    // Occupancy after a push this edge; a read is only in flight in FETCH
    // when the buffer holds at most one entry, so this never exceeds 2.
    count_after_push = count_q + 2'd1 - {1'b0, pop};

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (i_ready) begin
            req_addr_d = redirect_pc;
          end else begin
            // Read still in flight: keep the address stable until memory
            // answers, then restart from the remembered target.
            state_d   = DISCARD;
            pend_pc_d = redirect_pc;
          end
        end else if (i_ready) begin
          push       = 1'b1;
          req_addr_d = bp_predicted_pc;
          if (count_after_push == 2'd2) begin
            state_d = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (redirect_valid) begin
          req_addr_d = redirect_pc;
          state_d    = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (i_ready) begin
          req_addr_d = redirect_valid ? redirect_pc : pend_pc_q;
          state_d    = FETCH;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    fifo_d = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{instr:     i_data,
                           pc:        req_addr_q,
                           pred_pc:   bp_predicted_pc,
                           tag_match: bp_tag_match};
    end

    // A redirect flushes the buffer and wins over any push/pop this edge.
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      req_addr_q <= RESET_PC;
      pend_pc_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      pend_pc_q  <= pend_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a randomized run.
// The memory returns a fixed function of the address and the predictor is a
// simple function of the PC. The expected instruction stream is the
// program-order walk that follows the predictor from the latest reset or
// redirect target; a monitor pops it every time decode consumes a head entry.
module tb_fetch_unit;

  localparam int W = 16;
  localparam logic [W-1:0] RST_PC = 16'h0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_readM;
  logic [W-1:0] i_address;
  logic [W-1:0] i_data;
  logic         i_ready;
  logic [W-1:0] bp_pc;
  logic [W-1:0] bp_predicted_pc;
  logic         bp_tag_match;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         if_valid;
  logic [W-1:0] if_instr;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_pred_pc;
  logic         if_tag_match;
  logic         id_ready;

  logic         pred_mode;
  int           checks   = 0;
  int           failures = 0;
  int           consumed = 0;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
    logic [W-1:0] pred;
    logic         tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.WORD_SIZE(W), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_readM        (i_readM),
    .i_address      (i_address),
    .i_data         (i_data),
    .i_ready        (i_ready),
    .bp_pc          (bp_pc),
    .bp_predicted_pc(bp_predicted_pc),
    .bp_tag_match   (bp_tag_match),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pred_pc     (if_pred_pc),
    .if_tag_match   (if_tag_match),
    .id_ready       (id_ready)
  );

  // Memory contents and predictor behaviour as plain functions of the PC.
  function automatic logic [W-1:0] memf(input logic [W-1:0] pc);
    return {pc[7:0], pc[15:8]} ^ 16'hA5C3;
  endfunction

  function automatic logic [W-1:0] predf(input logic [W-1:0] pc, input logic m);
    if (m && pc[3:0] == 4'h0) return pc + 16'h0020;
    return pc + 16'h0001;
  endfunction

  function automatic logic tagf(input logic [W-1:0] pc, input logic m);
    return m && (pc[3:0] == 4'h0);
  endfunction

  assign i_data          = memf(i_address);
  assign bp_predicted_pc = predf(bp_pc, pred_mode);
  assign bp_tag_match    = tagf(bp_pc, pred_mode);

  function automatic exp_t mk(input logic [W-1:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = memf(pc);
    e.pred  = predf(pc, pred_mode);
    e.tag   = tagf(pc, pred_mode);
    return e;
  endfunction

  task automatic restart(input logic [W-1:0] pc);
    exp_q.delete();
    exp_q.push_back(mk(pc));
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [W-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    restart(pc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    restart(RST_PC);
  endtask

  // Monitor: checks protocol and pops the expected stream on consumption.
  logic         prev_v = 1'b0;
  logic         prev_readM, prev_ready, prev_reset;
  logic [W-1:0] prev_addr;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_readM", 16'(i_readM), 16'd0);
      chk("rst_if_valid", 16'(if_valid), 16'd0);
    end else begin
      if (prev_v && prev_readM && !prev_ready && !prev_reset)
        chk("addr_hold", i_address, prev_addr);
      if (if_valid && id_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_head actual_pc=%0h required=none", if_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("head_pc", if_pc, e.pc);
          chk("head_instr", if_instr, e.instr);
          chk("head_pred_pc", if_pred_pc, e.pred);
          chk("head_tag", 16'(if_tag_match), 16'(e.tag));
          consumed++;
          if (exp_q.size() == 0) exp_q.push_back(mk(e.pred));
        end
      end
    end
    prev_v     <= 1'b1;
    prev_readM <= i_readM;
    prev_ready <= i_ready;
    prev_reset <= reset;
    prev_addr  <= i_address;
  end

  initial begin
    reset          = 1'b1;
    i_ready        = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pred_mode      = 1'b0;
    restart(RST_PC);

    // Reset release, streaming with pc+1 predictor
    cyc(); cyc();
    reset = 1'b0;
    look();
    chk("rel_readM", 16'(i_readM), 16'd1);
    chk("rel_addr", i_address, RST_PC);
    chk("rel_valid", 16'(if_valid), 16'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); look();
      chk("stream_valid", 16'(if_valid), 16'd1);
      chk("stream_pc", if_pc, 16'(k));
    end

    // Stall: buffer fills, reads stop, pop restarts fetch at pc 2
    cyc(); id_ready = 1'b0; do_reset();
    cyc(); reset = 1'b0;
    look(); chk("st_addr0", i_address, 16'h0000);
    cyc(); look();
    chk("st_pc0", if_pc, 16'h0000);
    chk("st_addr1", i_address, 16'h0001);
    cyc(); look();
    chk("st_full_readM", 16'(i_readM), 16'd0);
    chk("st_full_head", if_pc, 16'h0000);
    cyc(); look();
    chk("st_hold_readM", 16'(i_readM), 16'd0);
    cyc(); id_ready = 1'b1;
    look(); chk("st_pop_readM", 16'(i_readM), 16'd0);
    cyc(); look();
    chk("st_resume_readM", 16'(i_readM), 16'd1);
    chk("st_resume_addr", i_address, 16'h0002);
    chk("st_resume_head", if_pc, 16'h0001);

    // Redirect while pc 5 read is outstanding
    cyc(); do_redirect(16'h0005); i_ready = 1'b1; look();
    cyc(); do_redirect(16'h0040); i_ready = 1'b0; look();
    chk("d_addr5", i_address, 16'h0005);
    cyc(); redirect_valid = 1'b0; look();
    chk("d_flushed", 16'(if_valid), 16'd0);
    chk("d_readM", 16'(i_readM), 16'd1);
    chk("d_hold1", i_address, 16'h0005);
    cyc(); look(); chk("d_hold2", i_address, 16'h0005);
    cyc(); i_ready = 1'b1; look();
    cyc(); i_ready = 1'b0; look();
    chk("d_new_addr", i_address, 16'h0040);
    chk("d_dropped", 16'(if_valid), 16'd0);
    cyc(); i_ready = 1'b1; look();
    cyc(); look();
    chk("d_first_valid", 16'(if_valid), 16'd1);
    chk("d_first_pc", if_pc, 16'h0040);

    // Redirect coincident with i_ready, then with a pop
    cyc(); do_redirect(16'h0007); look();
    cyc(); do_redirect(16'h0080); look();
    chk("c_addr7", i_address, 16'h0007);
    cyc(); redirect_valid = 1'b0; look();
    chk("c_drop7", 16'(if_valid), 16'd0);
    chk("c_addr80", i_address, 16'h0080);
    cyc(); look(); chk("c_pc80", if_pc, 16'h0080);
    cyc(); do_redirect(16'h0090); look();
    chk("c_pc81", if_pc, 16'h0081);
    cyc(); redirect_valid = 1'b0; look();
    chk("c_empty", 16'(if_valid), 16'd0);
    chk("c_addr90", i_address, 16'h0090);
    cyc(); look(); chk("c_pc90", if_pc, 16'h0090);

    // Predicted-taken entry
    cyc(); pred_mode = 1'b1; do_redirect(16'h0010); look();
    cyc(); redirect_valid = 1'b0; look();
    chk("p_addr10", i_address, 16'h0010);
    cyc(); look();
    chk("p_pc", if_pc, 16'h0010);
    chk("p_pred", if_pred_pc, 16'h0030);
    chk("p_tag", 16'(if_tag_match), 16'd1);
    chk("p_next_addr", i_address, 16'h0030);

    // Reset with full buffer, then reset while discarding
    id_ready = 1'b0;
    repeat (4) cyc();
    look();
    chk("r_full_readM", 16'(i_readM), 16'd0);
    chk("r_full_valid", 16'(if_valid), 16'd1);
    cyc(); do_reset(); look();
    cyc(); look();
    cyc(); reset = 1'b0; id_ready = 1'b1; look();
    chk("r_addr", i_address, RST_PC);
    chk("r_readM", 16'(i_readM), 16'd1);
    chk("r_valid", 16'(if_valid), 16'd0);
    cyc(); do_redirect(16'h0050); i_ready = 1'b1; look();
    cyc(); do_redirect(16'h0060); i_ready = 1'b0; look();
    cyc(); redirect_valid = 1'b0; do_reset(); i_ready = 1'b1; look();
    cyc(); reset = 1'b0; look();
    chk("rd_addr", i_address, RST_PC);
    chk("rd_readM", 16'(i_readM), 16'd1);
    cyc(); look();
    chk("rd_valid", 16'(if_valid), 16'd1);
    chk("rd_pc", if_pc, RST_PC);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      cyc();
      redirect_valid = 1'b0;
      reset          = 1'b0;
      id_ready       = ($urandom_range(0, 9) < 7);
      i_ready        = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 24) == 0) begin
        pred_mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0)
          do_redirect(16'hFFFC + 16'($urandom_range(0, 3)));
        else
          do_redirect(16'($urandom));
      end
    end
    cyc();
    redirect_valid = 1'b0;
    reset          = 1'b0;
    look();
    chk("progress", 16'(consumed >= 300), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, instruction/address width.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_readM  output  1  instruction-memory read request.
REQ-006 SHALL have port i_address  output  WORD_SIZE  read address, held stable while i_readM high.
REQ-007 SHALL have port i_data  input  WORD_SIZE  instruction word, valid when i_ready high.
REQ-008 SHALL have port i_ready  input  1  memory completes the outstanding read this cycle.
REQ-009 SHALL have port bp_pc  output  WORD_SIZE  PC being fetched, to branch predictor.
REQ-010 SHALL have port bp_predicted_pc  input  WORD_SIZE  predictor's next-PC for bp_pc (combinational).
REQ-011 SHALL have port bp_tag_match  input  1  predictor BTB hit for bp_pc.
REQ-012 SHALL have port redirect_valid  input  1  mispredict/jump correction from ID/EX.
REQ-013 SHALL have port redirect_pc  input  WORD_SIZE  corrected next PC.
REQ-014 SHALL have port if_valid  output  1  buffer head valid to decode.
REQ-015 SHALL have port if_instr  output  WORD_SIZE  head instruction.
REQ-016 SHALL have port if_pc  output  WORD_SIZE  head instruction's PC.
REQ-017 SHALL have port if_pred_pc  output  WORD_SIZE  next PC predicted for head (checked downstream).
REQ-018 SHALL have port if_tag_match  output  1  bp_tag_match captured with head.
REQ-019 SHALL have port id_ready  input  1  decode accepts head; low = stall.

Function
REQ-020 SHALL hold a 2-entry FIFO of {instr, pc, pred_pc, tag_match}; if_* driven from head, if_valid = (count != 0).
REQ-021 SHALL pop head at a clock edge where if_valid && id_ready && !redirect_valid.
REQ-022 SHALL have states FETCH (read outstanding), WAIT_SPACE (no read, FIFO full), DISCARD (read outstanding, result to be dropped).
REQ-023 SHALL drive i_readM = 1 in FETCH and DISCARD, 0 in WAIT_SPACE; at most one read outstanding.
REQ-024 SHALL drive i_address from register req_addr; bp_pc = req_addr.
REQ-025 FETCH, i_ready high, no redirect: push {i_data, req_addr, bp_predicted_pc, bp_tag_match}; req_addr <= bp_predicted_pc.
REQ-026 After REQ-025 push, SHALL go WAIT_SPACE if resulting count == 2, else stay FETCH issuing next read back-to-back (no idle cycle).
REQ-027 SHALL only issue a read when count + outstanding <= 2, so push never overflows; push and pop in same edge leave count unchanged.
REQ-028 WAIT_SPACE SHALL go FETCH at the edge where a pop occurs (req_addr unchanged).
REQ-029 Fetch latency: instruction returned with i_ready in cycle N SHALL appear on if_* with if_valid in cycle N+1.
REQ-030 redirect_valid at an edge SHALL flush FIFO (count <= 0), taking priority over push and pop in that edge.
REQ-031 Redirect with read outstanding and i_ready low: SHALL go DISCARD, keep req_addr/i_address stable, store redirect_pc in pend_pc.
REQ-032 Redirect with i_ready high, or in WAIT_SPACE: SHALL drop any returned data, req_addr <= redirect_pc, go FETCH.
REQ-033 DISCARD, i_ready high: SHALL drop i_data, req_addr <= pend_pc, go FETCH; further redirect in DISCARD overwrites pend_pc, stays DISCARD (unless i_ready high, then REQ-032).
REQ-034 PC arithmetic is WORD_SIZE wide, wraps 16'hFFFF -> 16'h0000 via predictor's pc+1 without special handling.

Reset
REQ-035 reset high at an edge SHALL set state FETCH, req_addr = RESET_PC, count = 0, pend_pc = 0; reset overrides redirect, i_ready, id_ready.
REQ-036 While reset high, i_readM SHALL be 0 and if_valid 0; first cycle after deassert i_readM = 1, i_address = RESET_PC.
REQ-037 Reset mid-read SHALL abandon the read; an i_ready in the first post-reset cycle completes the new RESET_PC read.

Verification
REQ-038 Reset release, i_ready=1 every cycle, predictor pc+1, id_ready=1 -> if_pc 0,1,2,3 on consecutive cycles, if_valid continuous from cycle 2.
REQ-039 id_ready=0, i_ready=1 -> two entries buffered (pc 0,1), i_readM=0 in WAIT_SPACE; raise id_ready -> pop pc 0, read of pc 2 issued next cycle.
REQ-040 Read of pc 5 outstanding, i_ready=0, redirect_pc=16'h0040 -> FIFO empty, i_address stays 5 until i_ready; data dropped; next i_address 16'h0040, if_pc 16'h0040 first valid.
REQ-041 Redirect to 16'h0080 same cycle as i_ready for pc 7 -> pc 7 never on if_*, next i_address 16'h0080; redirect coincident with pop -> no double count change.
REQ-042 bp_predicted_pc=16'h0030, bp_tag_match=1 for pc 16'h0010 -> entry shows if_pred_pc 16'h0030, if_tag_match 1; next i_address 16'h0030.
REQ-043 reset asserted with FIFO full and DISCARD pending -> next cycle count 0, i_readM 0; after release i_address = RESET_PC.
